// File: rtl/main_adapter_hub_source_pkg.sv
// Shared definitions for the hub-source adapter: default sizes, FSM
// state encodings and the tagged FIFO entry layout.
package main_adapter_hub_source_pkg;

  localparam int MAXLEN_DEFAULT = 15;
  localparam int DATA_W         = 64;

  // FSM encodings kept as plain vectors so legacy code can share them
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One FIFO entry: producer word plus its end-of-frame tag (65 bits)
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/main_adapter_hub_source_if.sv
// Command, producer and hub streams of the adapter bundled together.
// "master" is the adapter side, "slave" is the surrounding environment.
interface main_adapter_hub_source_if
  import main_adapter_hub_source_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEFAULT
);

  logic [MAXLEN-1:0] cmd;
  logic              cmd_isReady;
  logic              cmd_canReceive;

  logic [DATA_W-1:0] p__in;
  logic              p__in_isReady;
  logic              p__in_canReceive;
  logic              p__in_isLast;

  logic [DATA_W-1:0] h__out;
  logic              h__out_isReady;
  logic              h__out_canReceive;
  logic              h__out_isLast_in;
  logic              h__out_isLast_out;

  logic              busy;
  logic              early;

  modport master (
    input  cmd, cmd_isReady,
    output cmd_canReceive,
    input  p__in, p__in_isReady, p__in_isLast,
    output p__in_canReceive,
    output h__out, h__out_isReady, h__out_isLast_in,
    input  h__out_canReceive, h__out_isLast_out,
    output busy, early
  );

  modport slave (
    output cmd, cmd_isReady,
    input  cmd_canReceive,
    output p__in, p__in_isReady, p__in_isLast,
    input  p__in_canReceive,
    input  h__out, h__out_isReady, h__out_isLast_in,
    output h__out_canReceive, h__out_isLast_out,
    input  busy, early
  );

endinterface

// File: rtl/main_adapter_hub_source_fifo.sv
// Tagged synchronous FIFO with registered storage (no fall-through) and
// an extra wrap bit on each pointer to tell full from empty.
module bus_fifo_tagged #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head is masked while empty so stale storage never reaches the hub
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; a flush (early end) overrides any push/pop that cycle
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; validity is carried by the pointers alone.
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/main_adapter_hub_source.sv
// Hub-source adapter: accepts a word-count command, collects producer words
// into a tagged FIFO and streams them toward a busSwitch input, marking the
// final word and honouring an early end signalled by the hub.
module main_adapter_hub_source
  import main_adapter_hub_source_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MAXLEN = MAXLEN_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  main_adapter_hub_source_if.master bus
);

  localparam logic [MAXLEN-1:0] CNT_ONE = {{(MAXLEN-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [MAXLEN-1:0] remaining;
  logic              mode;       // 1 = counted, 0 = producer-framed
  logic              early_q;

  entry_t head;
  entry_t push_entry;
  logic   full, empty;
  logic   cmd_xfer, push, pop, tag, early_end, tagged_pop;

  assign bus.cmd_canReceive   = (state == ST_IDLE);
  assign bus.p__in_canReceive = (state == ST_RECV) & ~full;
  assign bus.h__out_isReady   = ~empty;
  assign bus.h__out           = head.data;
  assign bus.h__out_isLast_in = head.last & ~empty;
  assign bus.busy             = (state != ST_IDLE);
  assign bus.early            = early_q;

  assign cmd_xfer   = bus.cmd_isReady & bus.cmd_canReceive;
  assign push       = bus.p__in_isReady & bus.p__in_canReceive;
  assign pop        = bus.h__out_canReceive & ~empty;
  assign tag        = mode ? (remaining == CNT_ONE) : bus.p__in_isLast;
  assign tagged_pop = pop & head.last;
  // The hub ending the frame on an untagged word abandons the rest of it
  assign early_end  = pop & ~head.last & bus.h__out_isLast_out & (state != ST_IDLE);

  assign push_entry = '{last: tag, data: bus.p__in};

  bus_fifo_tagged #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (early_end),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Next-state selection for the IDLE/RECV/DRAIN frame sequencer
  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    case (state)
      ST_IDLE:  if (cmd_xfer) state_n = ST_RECV;
      ST_RECV: begin
        if (early_end || tagged_pop) state_n = ST_IDLE;
        else if (push && tag)        state_n = ST_DRAIN;
      end
      ST_DRAIN: if (early_end || tagged_pop) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register and the registered early-end pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      early_q <= 1'b0;
    end else begin
      state   <= state_n;
      early_q <= early_end;
    end
  end

  // Remaining-word counter: loaded per command, saturates at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      mode      <= 1'b0;
    end else if (cmd_xfer) begin
      remaining <= bus.cmd;
      mode      <= |bus.cmd;
    end else if (push && mode && (remaining != '0)) begin
      remaining <= remaining - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_main_adapter_hub_source.sv
// Directed bench for the hub-source adapter: a queue-based frame model is
// compared against every output each cycle, and each scenario also checks
// hand-computed counts, orderings and timings.
module tb_main_adapter_hub_source;

  localparam int DEPTH  = 4;
  localparam int MAXLEN = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_adapter_hub_source_if #(.MAXLEN(MAXLEN)) bus ();

  main_adapter_hub_source #(.DEPTH(DEPTH), .MAXLEN(MAXLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  typedef struct {
    logic [63:0] data;
    logic        last;
  } word_t;

  word_t mq[$];        // words buffered between producer and hub
  bit    m_active;     // frame in progress
  bit    m_accept;     // still taking producer words
  bit    m_early;      // early-end pulse visible this cycle
  int    m_left;       // words still owed in counted mode, -1 = producer-framed

  always @(posedge clk or negedge rst) begin : model
    bit    cx, px, hx, cut;
    word_t w;
    if (!rst) begin
      mq.delete();
      m_active = 0;
      m_accept = 0;
      m_early  = 0;
      m_left   = 0;
    end else begin
      cx  = !m_active && bus.cmd_isReady;
      px  = m_accept && (mq.size() < DEPTH) && bus.p__in_isReady;
      hx  = (mq.size() > 0) && bus.h__out_canReceive;
      cut = 0;
      m_early = 0;
      if (hx) begin
        w = mq.pop_front();
        if (w.last) begin
          m_active = 0;
          m_accept = 0;
        end else if (bus.h__out_isLast_out) begin
          cut      = 1;
          m_early  = 1;
          mq.delete();
          m_active = 0;
          m_accept = 0;
        end
      end
      if (px && !cut) begin
        w.data = bus.p__in;
        w.last = (m_left < 0) ? bus.p__in_isLast : (m_left == 1);
        mq.push_back(w);
        if (m_left > 0) m_left--;
        if (w.last) m_accept = 0;
      end
      if (cx) begin
        m_active = 1;
        m_accept = 1;
        m_left   = (bus.cmd == '0) ? -1 : int'(bus.cmd);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    check("cmd_canReceive",   64'(bus.cmd_canReceive),   64'(!m_active));
    check("p__in_canReceive", 64'(bus.p__in_canReceive), 64'(m_accept && (mq.size() < DEPTH)));
    check("h__out_isReady",   64'(bus.h__out_isReady),   64'(mq.size() > 0));
    check("h__out",           bus.h__out,                (mq.size() > 0) ? mq[0].data : 64'h0);
    check("h__out_isLast_in", 64'(bus.h__out_isLast_in), 64'((mq.size() > 0) ? mq[0].last : 1'b0));
    check("busy",             64'(bus.busy),             64'(m_active));
    check("early",            64'(bus.early),            64'(m_early));
  end

  // ---------------- stimulus helpers ----------------
  int    sent, frame, auto_n, early_at, early_cnt, cyc;
  bit    tag_pop_pending;
  word_t got[$];
  int    pop_cyc[$];

  task automatic tick();
    bit    pw, hw, cw;
    word_t w;
    @(negedge clk);
    cyc++;
    if (tag_pop_pending) begin
      check("cmd_rdy_after_last_pop", 64'(bus.cmd_canReceive), 64'(1));
      tag_pop_pending = 0;
    end
    pw = bus.p__in_isReady & bus.p__in_canReceive;
    hw = bus.h__out_isReady & bus.h__out_canReceive;
    cw = bus.cmd_isReady & bus.cmd_canReceive;
    if (bus.early) early_cnt++;
    if (hw) begin
      w.data = bus.h__out;
      w.last = bus.h__out_isLast_in;
      got.push_back(w);
      pop_cyc.push_back(cyc);
      if (bus.h__out_isLast_in) begin
        check("cmd_rdy_during_last_pop", 64'(bus.cmd_canReceive), 64'(0));
        tag_pop_pending = 1;
      end
    end
    @(posedge clk);
    #1;
    if (cw) bus.cmd_isReady = 1'b0;
    if (pw) begin
      sent++;
      bus.p__in        = {32'(frame), 32'(sent)};
      bus.p__in_isLast = (sent == auto_n - 1);
    end
    bus.h__out_isLast_out = (early_at != 0) && (got.size() == early_at - 1);
  endtask

  task automatic start_frame(input int c);
    frame++;
    sent = 0;
    got.delete();
    pop_cyc.delete();
    bus.cmd              = MAXLEN'(c);
    bus.cmd_isReady      = 1'b1;
    bus.p__in            = {32'(frame), 32'(0)};
    bus.p__in_isLast     = (auto_n == 1);
    bus.h__out_isLast_out = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((bus.busy || bus.cmd_isReady) && n < budget);
    check({name, "_frame_done"}, 64'(bus.busy | bus.cmd_isReady), 64'(0));
  endtask

  task automatic check_frame(input string name, input int n);
    check({name, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      check({name, "_data"}, got[i].data, {32'(frame), 32'(i)});
      check({name, "_last"}, 64'(got[i].last), 64'(i == n - 1));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cmd_canReceive"},   64'(bus.cmd_canReceive),   64'(1));
    check({name, "_p__in_canReceive"}, 64'(bus.p__in_canReceive), 64'(0));
    check({name, "_h__out_isReady"},   64'(bus.h__out_isReady),   64'(0));
    check({name, "_h__out_isLast_in"}, 64'(bus.h__out_isLast_in), 64'(0));
    check({name, "_busy"},             64'(bus.busy),             64'(0));
    check({name, "_h__out"},           bus.h__out,                64'h0);
    check({name, "_early"},            64'(bus.early),            64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s, c0;
    bus.cmd               = '0;
    bus.cmd_isReady       = 1'b0;
    bus.p__in             = '0;
    bus.p__in_isReady     = 1'b0;
    bus.p__in_isLast      = 1'b0;
    bus.h__out_canReceive = 1'b0;
    bus.h__out_isLast_out = 1'b0;
    auto_n   = 0;
    early_at = 0;

    // Power-on reset
    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Counted cmd=3, both sides always ready
    bus.h__out_canReceive = 1'b1;
    bus.p__in_isReady     = 1'b1;
    start_frame(3);
    wait_idle(20, "cnt3");
    check_frame("cnt3", 3);

    // Producer-framed, 5 words, 6th refused
    auto_n = 5;
    start_frame(0);
    wait_idle(30, "auto5");
    check_frame("auto5", 5);
    check("auto5_sent", 64'(sent), 64'(5));
    tick();
    tick();
    check("auto5_sixth_refused", 64'(sent), 64'(5));
    auto_n = 0;

    // Backpressure: DEPTH=4, cmd=6, hub stalled for 10 cycles
    bus.h__out_canReceive = 1'b0;
    start_frame(6);
    repeat (10) tick();
    check("bp_pushes_before_full", 64'(sent), 64'(4));
    check("bp_p_canReceive_low", 64'(bus.p__in_canReceive), 64'(0));
    bus.h__out_canReceive = 1'b1;
    wait_idle(30, "bp6");
    check_frame("bp6", 6);

    // Early end from the hub on the 2nd pop of a cmd=8 frame
    early_cnt = 0;
    early_at  = 2;
    start_frame(8);
    wait_idle(30, "early");
    s = sent;
    repeat (3) tick();
    early_at = 0;
    check("early_pulse_count", 64'(early_cnt), 64'(1));
    check("early_pops", 64'(got.size()), 64'(2));
    check("early_pop1_untagged", 64'(got[1].last), 64'(0));
    check("early_fifo_empty", 64'(bus.h__out_isReady), 64'(0));
    check("early_idle", 64'(bus.busy), 64'(0));
    check("early_no_more_requests", 64'(sent), 64'(s));

    // Reset during DRAIN with two words buffered
    bus.h__out_canReceive = 1'b0;
    start_frame(2);
    repeat (5) tick();
    check("drain_busy", 64'(bus.busy), 64'(1));
    check("drain_buffered", 64'(bus.h__out_isReady), 64'(1));
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.h__out_canReceive = 1'b1;
    start_frame(1);
    wait_idle(10, "post_rst");
    check_frame("post_rst", 1);

    // Back-to-back cmd=1 frames: 3 cycles each (cmd, push, pop)
    c0 = cyc;
    repeat (4) begin
      start_frame(1);
      wait_idle(10, "b2b1");
      check_frame("b2b1", 1);
    end
    check("b2b1_cycles", 64'(cyc - c0), 64'(12));

    // Streaming cmd=8: one word per cycle on the hub side
    start_frame(8);
    wait_idle(30, "stream8");
    check_frame("stream8", 8);
    if (pop_cyc.size() == 8)
      check("stream8_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'(7));
    else
      check("stream8_pops", 64'(pop_cyc.size()), 64'(8));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_adapter_hub_source.md
MAIN_ADAPTER_HUB_SOURCE -- requirements
Module: main_adapter_hub_source

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter MAXLEN, default 15, meaning width of the word-count field.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port cmd, input, MAXLEN, meaning word count; 0 selects automatic (producer-framed) mode.
REQ-006 SHALL have ports cmd_isReady (input, 1) and cmd_canReceive (output, 1), meaning command handshake.
REQ-007 SHALL have ports p__in (input, 64), p__in_isReady (input, 1), p__in_canReceive (output, 1) and p__in_isLast (input, 1), meaning the producer-side stream; p__in_isLast is used in automatic mode only.
REQ-008 SHALL have ports h__out (output, 64), h__out_isReady (output, 1), h__out_canReceive (input, 1), h__out_isLast_in (output, 1) and h__out_isLast_out (input, 1), meaning the hub-side stream toward a busSwitch input.
REQ-009 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-010 SHALL have port early, output, 1, meaning a one-cycle pulse when the frame is cut short by the hub.

Function
REQ-011 SHALL define a transfer on either stream as isReady & canReceive high in the same cycle.
REQ-012 SHALL implement a three-state FSM:
  - IDLE: cmd_canReceive=1; a cmd transfer moves to RECV.
  - RECV: accepts producer words.
  - DRAIN: accepts no producer words; empties the FIFO.
REQ-013 SHALL, on cmd acceptance, load the remaining-count register with cmd and latch mode = (cmd != 0).
REQ-014 SHALL drive p__in_canReceive = (state==RECV) & ~full.
REQ-015 SHALL push each accepted word together with a last tag:
  - counted mode: tag = (remaining == 1); remaining decrements per push.
  - automatic mode: tag = p__in_isLast.
REQ-016 SHALL move RECV->DRAIN in the cycle a tagged word is pushed, or in the cycle that tagged word is also popped (REQ-020 then applies).
REQ-017 SHALL not fall through: a word pushed in cycle t is visible on h__out no earlier than t+1. h__out_isReady = ~empty.
REQ-018 SHALL drive h__out_isLast_in = head tag & ~empty.
REQ-019 SHALL support simultaneous push and pop in one cycle, giving one word per cycle sustained throughput.
REQ-020 SHALL return to IDLE after a pop of a tagged entry; cmd_canReceive rises the following cycle, never in the same cycle.
REQ-021 SHALL treat h__out_isLast_out=1 on a pop of an untagged entry as early end:
  - flush the FIFO;
  - pulse early for one cycle;
  - go to IDLE, discarding unsent words;
  - producer words still outstanding in counted mode are not requested.
REQ-022 SHALL ignore h__out_isLast_out when no pop occurs.
REQ-023 SHALL drive busy = (state != IDLE).
REQ-024 SHALL handle counted-mode cmd=1: the first word pushed is tagged and RECV->DRAIN follows immediately.
REQ-025 SHALL use an unsigned MAXLEN-bit counter that never wraps; cmd=2^MAXLEN-1 is legal.
REQ-026 SHALL use FIFO pointers of log2(DEPTH)+1 bits: full when MSBs differ and the rest are equal; empty when equal.

Reset
REQ-027 SHALL, while rst=0 (asynchronous), force:
  - state=IDLE;
  - FIFO empty, pointers 0;
  - remaining=0, mode=0;
  - early=0.
  Resulting outputs: cmd_canReceive=1, p__in_canReceive=0, h__out_isReady=0, h__out_isLast_in=0, busy=0, h__out=0.
REQ-028 SHALL abandon any frame in progress when reset is asserted mid-frame, with no output glitch after release.

Structure
REQ-029 SHALL place MAXLEN default and the FSM state encodings in the shared definitions (lib.v).
REQ-030 SHALL instantiate one sub-module, bus_fifo_tagged (65-bit entries, DEPTH parameter); the FSM and counter sit at top level.

Verification
REQ-031 SHALL cover counted cmd=3, producer always ready, hub always ready -> h__out words 3, isLast_in on the 3rd only, cmd_canReceive back 1 cycle after the final pop.
REQ-032 SHALL cover automatic cmd=0, 5 words with p__in_isLast on the 5th -> 5 words out in order, isLast_in on the 5th, 6th producer word refused.
REQ-033 SHALL cover DEPTH=4, counted cmd=6, h__out_canReceive=0 for 10 cycles -> p__in_canReceive falls after 4 pushes, then all 6 words delivered once canReceive=1.
REQ-034 SHALL cover counted cmd=8 with h__out_isLast_out=1 on the 2nd pop -> early pulses once, FIFO empties, state IDLE, no further producer requests.
REQ-035 SHALL cover reset pulled low during DRAIN with 2 words buffered -> all outputs at reset values immediately; after release a cmd=1 frame completes normally.
REQ-036 SHALL cover counted cmd=1 with simultaneous push/pop streaming -> a single word with isLast_in, one word per cycle sustained over back-to-back frames.
